// File: rtl/mic_sample_fifo_if.sv
// Wishbone bus bundles shared by mic_sample_fifo and its users.
// Controller-side and peripheral-side signals are packed structs so each bus direction is a single port.
package mic_wb_pkg;

    localparam int WB_AW = 8;
    localparam int WB_DW = 32;

    typedef struct packed {
        logic             stb;
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
    } iWishbone_Ctrl;

    typedef struct packed {
        logic             ack;
        logic [WB_DW-1:0] dat;
    } iWishbone_Peri;

endpackage

// File: rtl/mic_sample_fifo.sv
// PCM sample FIFO exposed as a Wishbone peripheral with a level-threshold irq.
// Optional macro MIC_FIFO_SIGNED_EN: DATA reads return the sample re-centred to two's complement.
module mic_sample_fifo
    import mic_wb_pkg::*;
#(
    parameter int pAudioBits = 16,
    parameter int pDepth     = 16,
    parameter int pIrqLevel  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  iWishbone_Ctrl         wb_c,
    output iWishbone_Peri         wb_p,
    input  logic [pAudioBits-1:0] sample_dat,
    input  logic                  sample_stb,
    output logic                  irq
);

    localparam int AW = $clog2(pDepth);
    localparam int LW = AW + 1;

    logic [pAudioBits-1:0] mem [pDepth];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             irq_en_q, irq_en_d;
    logic [7:0]       thresh_q, thresh_d;
    logic             ack_q, ack_d;
    logic [WB_DW-1:0] dat_q, dat_d;
    logic             irq_q, irq_d;

    logic empty, full;
    logic accept, rd_en, wr_en;
    logic pop, ctrl_wr, thresh_wr, flush, clr_ovf;
    logic push, ovf_evt;
    logic [pAudioBits-1:0] rd_sample;
    logic [WB_DW-1:0]      sample_ext;
    logic                  unused_wb_dat;

    assign empty  = (level_q == '0);
    assign full   = (level_q == LW'(pDepth));

    assign accept    = wb_c.stb && !ack_q;
    assign rd_en     = accept && !wb_c.we;
    assign wr_en     = accept && wb_c.we;
    assign pop       = rd_en && (wb_c.adr == WB_AW'(0)) && !empty;
    assign ctrl_wr   = wr_en && (wb_c.adr == WB_AW'(2));
    assign thresh_wr = wr_en && (wb_c.adr == WB_AW'(3));
    assign flush     = ctrl_wr && wb_c.dat[1];
    assign clr_ovf   = ctrl_wr && wb_c.dat[2];

    // A pop in the same cycle frees the slot, so a full FIFO can still take the sample.
    assign push    = sample_stb && !flush && (!full || pop);
    assign ovf_evt = sample_stb && !flush && full && !pop;

    assign rd_sample = mem[rd_ptr_q];

`ifdef MIC_FIFO_SIGNED_EN
    logic [pAudioBits-1:0] centred;
    assign centred    = {~rd_sample[pAudioBits-1], rd_sample[pAudioBits-2:0]};
    assign sample_ext = WB_DW'(signed'(centred));
`else
    assign sample_ext = WB_DW'(rd_sample);
`endif

    assign unused_wb_dat = ^wb_c.dat[WB_DW-1:8];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        ack_d    = accept;
        dat_d    = '0;
        irq_d    = irq_en_q && (32'(level_q) >= 32'(thresh_q));

        if (rd_en) begin
            case (wb_c.adr)
                WB_AW'(0): dat_d = empty ? '0 : sample_ext;
                WB_AW'(1): dat_d = WB_DW'({8'(level_q), 5'b0, ovf_q, full, empty});
                WB_AW'(2): dat_d = WB_DW'(irq_en_q);
                WB_AW'(3): dat_d = WB_DW'(thresh_q);
                default:   dat_d = '0;
            endcase
        end

        if (ctrl_wr) irq_en_d = wb_c.dat[0];
        if (thresh_wr) thresh_d = wb_c.dat[7:0];
        if (clr_ovf) ovf_d = 1'b0;
        if (ovf_evt) ovf_d = 1'b1;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= sample_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            thresh_q <= 8'(pIrqLevel);
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            irq_q    <= irq_d;
        end
    end

    assign wb_p.ack = ack_q;
    assign wb_p.dat = dat_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_mic_sample_fifo.sv
// Scoreboard bench for mic_sample_fifo: queue-based reference model, per-cycle ack/irq checks, read data popped on ack.
module tb_mic_sample_fifo;
    import mic_wb_pkg::*;

    localparam int DEPTH = 16;
    localparam int IRQ_LVL = 8;

    logic          clk = 1'b0;
    logic          rst;
    iWishbone_Ctrl wb_c;
    iWishbone_Peri wb_p;
    logic [15:0]   sample_dat;
    logic          sample_stb;
    logic          irq;

    always #5 clk = ~clk;

    mic_sample_fifo #(.pAudioBits(16), .pDepth(DEPTH), .pIrqLevel(IRQ_LVL)) dut (
        .clk(clk), .rst(rst), .wb_c(wb_c), .wb_p(wb_p),
        .sample_dat(sample_dat), .sample_stb(sample_stb), .irq(irq)
    );

    typedef struct {
        bit          rd;
        logic [7:0]  adr;
        logic [31:0] v;
    } exp_t;

    logic [15:0] mq[$];
    exp_t        exp_q[$];
    bit          m_ovf, m_irq_en, m_ack, exp_irq, mon_en;
    logic [7:0]  m_thresh;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic [31:0] conv(logic [15:0] x);
`ifdef MIC_FIFO_SIGNED_EN
        logic [15:0] t;
        t = x ^ 16'h8000;
        return {{16{t[15]}}, t};
`else
        return {16'h0, x};
`endif
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    endtask

    // Reference model: advances one clock using the pre-edge state and the inputs driven during that cycle.
    task automatic model_update(bit r, bit stb, bit we, logic [7:0] adr, logic [31:0] wd, bit ss, logic [15:0] sd);
        bit          acc;
        bit          flush;
        logic [31:0] v;
        if (r) begin
            mq.delete();
            exp_q.delete();
            m_ovf = 0; m_irq_en = 0; m_thresh = 8'(IRQ_LVL); m_ack = 0; exp_irq = 0;
            return;
        end
        exp_irq = m_irq_en && (mq.size() >= int'(m_thresh));
        acc = stb && !m_ack;
        m_ack = acc;
        flush = 0;
        if (acc && !we) begin
            case (adr)
                8'd0: v = (mq.size() == 0) ? 32'h0 : conv(mq.pop_front());
                8'd1: v = {16'h0, 8'(mq.size()), 5'h0, m_ovf, mq.size() == DEPTH, mq.size() == 0};
                8'd2: v = {31'h0, m_irq_en};
                8'd3: v = {24'h0, m_thresh};
                default: v = 32'h0;
            endcase
            exp_q.push_back('{1'b1, adr, v});
        end else if (acc) begin
            if (adr == 8'd2) begin
                m_irq_en = wd[0];
                flush = wd[1];
                if (wd[2]) m_ovf = 0;
                if (flush) mq.delete();
            end
            if (adr == 8'd3) m_thresh = wd[7:0];
            exp_q.push_back('{1'b0, adr, 32'h0});
        end
        if (ss && !flush) begin
            if (mq.size() < DEPTH) mq.push_back(sd);
            else m_ovf = 1;
        end
    endtask

    task automatic step(bit r, bit stb, bit we, logic [7:0] adr, logic [31:0] wd, bit ss, logic [15:0] sd);
        rst = r;
        wb_c = '{stb, we, adr, wd};
        sample_stb = ss;
        sample_dat = sd;
        @(posedge clk);
        model_update(r, stb, we, adr, wd, ss, sd);
        #1;
    endtask

    task automatic idle(bit ss, logic [15:0] sd);
        step(0, 0, 0, 8'd0, 32'h0, ss, sd);
    endtask

    task automatic rd(logic [7:0] adr);
        step(0, 1, 0, adr, 32'h0, 0, 16'h0);
        idle(0, 16'h0);
    endtask

    task automatic wr(logic [7:0] adr, logic [31:0] d);
        step(0, 1, 1, adr, d, 0, 16'h0);
        idle(0, 16'h0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("ack", {31'h0, wb_p.ack}, {31'h0, m_ack});
            check("irq", {31'h0, irq}, {31'h0, exp_irq});
            if (wb_p.ack) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_ack: got ack=1 required no transaction pending");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.rd) begin
                        check("rdata", wb_p.dat, e.v);
                        $display("rd adr=%0d dat=%h exp=%h", e.adr, wb_p.dat, e.v);
                    end else begin
                        $display("wr adr=%0d acked", e.adr);
                    end
                end
            end
        end
    end

    initial begin
        mon_en = 0;
        wb_c = '0;
        sample_stb = 0;
        sample_dat = '0;
        rst = 1;
        step(1, 0, 0, 8'd0, 32'h0, 0, 16'h0);
        step(1, 0, 0, 8'd0, 32'h0, 0, 16'h0);
        mon_en = 1;
        check("rst_dat", wb_p.dat, 32'h0);
        check("rst_ack", {31'h0, wb_p.ack}, 32'h0);

        // Basic push/pop ordering and empty status
        idle(1, 16'h0001); idle(1, 16'h8000); idle(1, 16'hFFFF);
        rd(0); rd(0); rd(0); rd(1);

        // Overflow on the 17th sample, then W1C clear
        for (int i = 0; i < 17; i++) idle(1, 16'(16'h0100 + i));
        rd(1); rd(0); wr(2, 32'h4); rd(1);
        idle(1, 16'h0200);
        rd(1);

        // Full FIFO: pop and push in the same cycle
        step(0, 1, 0, 8'd0, 32'h0, 1, 16'hABCD);
        idle(0, 16'h0);
        rd(1);

        // Empty FIFO: pop and push in the same cycle
        wr(2, 32'h2);
        rd(1);
        step(0, 1, 0, 8'd0, 32'h0, 1, 16'h1234);
        idle(0, 16'h0);
        rd(1); rd(0);

        // irq threshold behaviour
        wr(2, 32'h1); wr(3, 32'h4);
        for (int i = 0; i < 3; i++) begin idle(1, 16'(i + 1)); idle(0, 16'h0); end
        idle(1, 16'h0004); idle(0, 16'h0); idle(0, 16'h0);
        rd(0); idle(0, 16'h0); idle(0, 16'h0);

        // Flush with a coincident sample, then reset mid-transfer
        wr(2, 32'h2);
        for (int i = 0; i < 5; i++) idle(1, 16'(16'h0300 + i));
        step(0, 1, 1, 8'd2, 32'h3, 1, 16'h5555);
        idle(0, 16'h0);
        rd(1);
        step(1, 1, 0, 8'd1, 32'h0, 0, 16'h0);
        check("rst_mid_ack", {31'h0, wb_p.ack}, 32'h0);
        idle(0, 16'h0);
        rd(3); rd(2);

        // Threshold 0 holds irq asserted
        wr(3, 32'h0); wr(2, 32'h1);
        for (int i = 0; i < 4; i++) idle(0, 16'h0);
        rd(7); wr(0, 32'hFFFF); wr(1, 32'h1);

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            int          c;
            logic [7:0]  a;
            logic [31:0] d;
            bit          w;
            c = $urandom_range(0, 99);
            if (c == 0) begin
                step(1, $urandom_range(0, 1), 0, 8'd1, 32'h0, 0, 16'h0);
            end else if (c < 50) begin
                idle($urandom_range(0, 9) < 7, 16'($urandom));
            end else begin
                a = 8'($urandom_range(0, 4));
                w = (a >= 2) ? $urandom_range(0, 1) : ($urandom_range(0, 9) == 0);
                d = 32'h0;
                if (a == 8'd2) d = {29'h0, ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom)};
                else if (a == 8'd3) d = 32'($urandom_range(0, 20));
                else d = $urandom;
                step(0, 1, w, a, d, $urandom_range(0, 1), 16'($urandom));
                step(0, $urandom_range(0, 1), w, a, d, $urandom_range(0, 1), 16'($urandom));
            end
        end

        for (int i = 0; i < 3; i++) idle(0, 16'h0);
        check("drain", 32'(exp_q.size()), 32'h0);
        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
